// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path: frame FSM encoding,
// scan-code prefix values and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Odd parity holds when the data bits plus the parity bit have an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Signal bundle between the PS/2 receiver and its neighbours: raw PS/2 lines in,
// decoded scan-code strobe, error pulses and the FSM state (for observation) out.
interface ps2_rx_if;
  import ps2_pkg::*;

  // Handshake: code_valid is a single-cycle strobe with no back-pressure; code,
  // is_break and is_ext are valid in that cycle and held until the next strobe.
  logic       PS2C;
  logic       PS2D;
  logic [7:0] code;
  logic       code_valid;
  logic       is_break;
  logic       is_ext;
  logic       parity_err;
  logic       frame_err;
  ps2_state_t dbg_state;

  modport master (
    input  PS2C, PS2D,
    output code, code_valid, is_break, is_ext, parity_err, frame_err, dbg_state
  );

  modport slave (
    output PS2C, PS2D,
    input  code, code_valid, is_break, is_ext, parity_err, frame_err, dbg_state
  );

endinterface

// File: rtl/ps2_filter.sv
// Conditions one raw PS/2 line: 2-FF synchroniser, FILTER_LEN-sample debouncer
// and a registered falling-edge strobe of the filtered level.
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk256,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;
  logic          r_fall;
  logic          w_sync;

  assign w_sync = r_sync[1];

  always_ff @(posedge clk256) begin
    if (reset) begin
      r_sync    <= 2'b11;
      r_cnt     <= '0;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
      r_fall    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_raw};
      r_level_d <= r_level;
      r_fall    <= r_level_d & ~r_level;
      // Count consecutive samples that disagree with the filtered level; any
      // agreeing sample restarts the run, so short glitches never get through.
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_level <= w_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: deserialises 11-bit frames, checks start/parity/stop,
// folds E0/F0 prefixes into flags and emits one code_valid strobe per key event.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 2048
) (
  input  logic     clk256,
  input  logic     reset,
  ps2_rx_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic          w_fall;
  logic          w_data;

  ps2_state_t    r_state, w_state_next;
  logic [2:0]    r_bit_cnt, w_bit_cnt_next;
  logic [7:0]    r_shift, w_shift_next;
  logic          r_par, w_par_next;
  logic [TW-1:0] r_to_cnt, w_to_cnt_next;
  logic          r_ext_pend, w_ext_pend_next;
  logic          r_brk_pend, w_brk_pend_next;
  logic [7:0]    r_code, w_code_next;
  logic          r_is_break, w_is_break_next;
  logic          r_is_ext, w_is_ext_next;
  logic          r_code_valid, w_code_valid_next;
  logic          r_parity_err, w_parity_err_next;
  logic          r_frame_err, w_frame_err_next;
  logic          w_timeout;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk256  (clk256),
    .reset   (reset),
    .i_raw   (bus.PS2C),
    .o_level (),
    .o_fall  (w_fall)
  );

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk256  (clk256),
    .reset   (reset),
    .i_raw   (bus.PS2D),
    .o_level (w_data),
    .o_fall  ()
  );

  always_ff @(posedge clk256) begin
    if (reset) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_to_cnt     <= '0;
      r_ext_pend   <= 1'b0;
      r_brk_pend   <= 1'b0;
      r_code       <= 8'h00;
      r_is_break   <= 1'b0;
      r_is_ext     <= 1'b0;
      r_code_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_shift      <= w_shift_next;
      r_par        <= w_par_next;
      r_to_cnt     <= w_to_cnt_next;
      r_ext_pend   <= w_ext_pend_next;
      r_brk_pend   <= w_brk_pend_next;
      r_code       <= w_code_next;
      r_is_break   <= w_is_break_next;
      r_is_ext     <= w_is_ext_next;
      r_code_valid <= w_code_valid_next;
      r_parity_err <= w_parity_err_next;
      r_frame_err  <= w_frame_err_next;
    end
  end

  assign w_timeout = (r_state != IDLE) && (r_to_cnt == TW'(TIMEOUT));

  always_comb begin
    w_state_next      = r_state;
    w_bit_cnt_next    = r_bit_cnt;
    w_shift_next      = r_shift;
    w_par_next        = r_par;
    w_ext_pend_next   = r_ext_pend;
    w_brk_pend_next   = r_brk_pend;
    w_code_next       = r_code;
    w_is_break_next   = r_is_break;
    w_is_ext_next     = r_is_ext;
    w_code_valid_next = 1'b0;
    w_parity_err_next = 1'b0;
    w_frame_err_next  = 1'b0;
    w_to_cnt_next     = (r_state == IDLE || w_fall) ? '0 : r_to_cnt + 1'b1;

    if (w_timeout) begin
      // A stalled frame also forgets any half-received prefix sequence.
      w_state_next     = IDLE;
      w_bit_cnt_next   = '0;
      w_to_cnt_next    = '0;
      w_frame_err_next = 1'b1;
      w_ext_pend_next  = 1'b0;
      w_brk_pend_next  = 1'b0;
    end else if (w_fall) begin
      case (r_state)
        IDLE: begin
          if (!w_data) begin
            w_state_next   = DATA;
            w_bit_cnt_next = '0;
          end else begin
            w_frame_err_next = 1'b1;
          end
        end
        DATA: begin
          w_shift_next = {w_data, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_state_next   = PARITY;
            w_bit_cnt_next = '0;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          w_par_next   = w_data;
          w_state_next = STOP;
        end
        STOP: begin
          w_state_next = IDLE;
          if (!w_data) begin
            w_frame_err_next = 1'b1;
          end else if (!odd_parity_ok(r_shift, r_par)) begin
            w_parity_err_next = 1'b1;
          end else if (r_shift == PS2_EXT) begin
            w_ext_pend_next = 1'b1;
          end else if (r_shift == PS2_BRK) begin
            w_brk_pend_next = 1'b1;
          end else begin
            w_code_next       = r_shift;
            w_is_break_next   = r_brk_pend;
            w_is_ext_next     = r_ext_pend;
            w_code_valid_next = 1'b1;
            w_ext_pend_next   = 1'b0;
            w_brk_pend_next   = 1'b0;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign bus.code       = r_code;
  assign bus.code_valid = r_code_valid;
  assign bus.is_break   = r_is_break;
  assign bus.is_ext     = r_is_ext;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.dbg_state  = r_state;

endmodule
